hazard_resolve_unit: RTL and testbench
======================================

// Module: hazard_resolve_unit
// PURPOSE
//  Parametrised successor to the combinational load-use/forward comparator, for the RV32IM pipeline.
//  - Resolves RAW hazards for NUM_SRC decode-stage source operands.
//  - Produces forwarding selects and multi-cycle load-use stall/bubble controls.
//  - Owns a small FSM, so stalls can span LOAD_USE_STALL cycles and survive pipeline freeze.
//  - Sits between ID/EX and the pipeline registers, replacing the separate forward unit + comparator.
// PARAMETERS
//  NUM_SRC         2   source operands checked per instruction (1..3; 3 reserved for R4 formats)
//  REG_ADDR_W      5   register address width
//  LOAD_USE_STALL  1   bubbles inserted per load-use hazard (1..3; 1 = load data forwardable from MEM)
// PORTS
//  CLK             in   1                   clock
//  RESET           in   1                   synchronous, active-high
//  ID_VALID        in   1                   instruction in ID is real (not a bubble)
//  ID_RS_ADDR      in   NUM_SRC*REG_ADDR_W  source addresses; src i at [i*REG_ADDR_W +: REG_ADDR_W]
//  ID_RS_USED      in   NUM_SRC             source i is actually read
//  EX_RD           in   REG_ADDR_W          destination of the instruction in EX
//  EX_REG_WRITE    in   1                   EX instruction writes the register file
//  EX_MEM_READ     in   1                   EX instruction is a load
//  MEM_RD          in   REG_ADDR_W          destination in MEM
//  MEM_REG_WRITE   in   1                   MEM writes the register file
//  WB_RD           in   REG_ADDR_W          destination in WB
//  WB_REG_WRITE    in   1                   WB writes the register file
//  FLUSH           in   1                   taken branch/jump; cancels ID instruction and any pending stall
//  FORWARD_SEL     out  2*NUM_SRC           per source: 00 regfile, 01 EX/MEM (ALU or load data), 10 MEM/WB
//  STALL_PC        out  1                   hold PC
//  STALL_IFID      out  1                   hold IF/ID register
//  BUBBLE_IDEX     out  1                   load NOP into ID/EX
//  MULDIV_BUSY     in   1                   [MULDIV_STALL_EN only] M-unit in EX not finished
// BEHAVIOUR
//  - Reset (sync): state=IDLE, counter=0.
//    - Outputs while RESET=1: STALL_*=0, BUBBLE_IDEX=0, FORWARD_SEL=0.
//  - Forward (combinational, zero latency), per source i, applied only when ID_RS_USED[i]=1 and rs!=x0:
//    - MEM_REG_WRITE && MEM_RD==rs -> 01.
//    - else WB_REG_WRITE && WB_RD==rs -> 10.
//    - else 00.
//    - Newest producer wins. x0 never forwards.
//  - Load-use detect: lu = ID_VALID && EX_MEM_READ && EX_REG_WRITE && EX_RD!=0
//    && any used source == EX_RD.
//  - FSM states: IDLE, LU_HOLD, MD_WAIT.
//    - IDLE, lu, LOAD_USE_STALL==1: stall+bubble this cycle only; stay IDLE.
//    - IDLE, lu, LOAD_USE_STALL>1: stall+bubble this cycle; counter<=LOAD_USE_STALL-1; ->LU_HOLD.
//    - LU_HOLD: stall+bubble asserted; counter decrements; ->IDLE when it reaches 0.
//      - lu is ignored here; the bubble now sits in EX.
//  - Stall output rule: STALL_PC = STALL_IFID = BUBBLE_IDEX = (cycle is a stall cycle).
//    - Asserted in the same cycle as detection.
//  - After the final bubble, the load has reached MEM (or WB), so the normal forward priority yields 01 (or 10).
//    - No sticky select is stored.
//  - FLUSH: highest priority; forces state IDLE, counter 0, STALL_*=0. The caller inserts its own bubble.
//  - FLUSH and lu in the same cycle: FLUSH wins, no stall.
//  - RESET mid-stall: stall aborted next edge, outputs 0.
//  - Counter width is $clog2(LOAD_USE_STALL+1); no wrap is possible.
// CONFIGURATION
//  - Macro HAZARD_MULDIV_STALL_EN.
//  - Defined: MULDIV_BUSY port exists.
//    - IDLE/LU_HOLD with MULDIV_BUSY -> MD_WAIT.
//    - MD_WAIT holds STALL_PC and STALL_IFID, plus a hold on EX signalled via BUBBLE_IDEX=0, until MULDIV_BUSY=0, then ->IDLE.
//    - A pending LU counter is frozen and resumed after MD_WAIT.
//    - FLUSH does not abort MD_WAIT.
//  - Undefined: no port, MD_WAIT unreachable, and the state is removed by synthesis.
// STRUCTURE
//  - Package hazard_pkg:
//    - FWD_REGFILE/FWD_EXMEM/FWD_MEMWB 2-bit constants.
//    - hz_state_t enum {IDLE, LU_HOLD, MD_WAIT}.
//  - Sub-module hazard_src_match: one instance per source (generate loop).
//    - Compares one rs against EX/MEM/WB destinations.
//    - Outputs fwd_sel[1:0] and lu_hit.
// TESTING
//  - ALU chain: add x5 in MEM; ID uses rs1=x5 -> FORWARD_SEL[1:0]=01, no stall.
//  - Double producer: MEM_RD=WB_RD=x7 both writing; rs2=x7 -> FORWARD_SEL[3:2]=01 (MEM wins).
//  - x0 rule: EX load to x0, rs1=x0 -> no stall, FORWARD_SEL=00.
//  - LOAD_USE_STALL=1: lw x3 in EX, ID rs1=x3 -> one-cycle stall/bubble.
//    - Next cycle MEM_RD=x3 -> FORWARD_SEL[1:0]=01.
//  - LOAD_USE_STALL=3: same stimulus -> stall for exactly 3 cycles.
//    - FLUSH in cycle 2 drops stall on that cycle.
//    - RESET in cycle 2 -> all outputs 0 next edge.
//  - HAZARD_MULDIV_STALL_EN: MULDIV_BUSY high for 5 cycles -> STALL_PC high those 5 cycles, low on the 6th.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard resolve unit: forwarding selects and FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LU_HOLD = 2'd1,
        MD_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_resolve_unit_src_match.sv
// Per-source RAW comparator: picks the newest forwarding producer and flags a load-use hit.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    output logic [1:0]            fwd_sel,
    output logic                  lu_hit
);

    logic live;

    // x0 is hard-wired zero, so it never takes part in forwarding or stalls.
    assign live = used && (rs != '0);

    always_comb begin
        fwd_sel = FWD_REGFILE;
        if (live && mem_reg_write && (mem_rd == rs)) begin
            fwd_sel = FWD_EXMEM;
        end else if (live && wb_reg_write && (wb_rd == rs)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

    assign lu_hit = live && ex_mem_read && ex_reg_write && (ex_rd == rs);

endmodule

// File: rtl/hazard_resolve_unit.sv
// Hazard resolve unit: forwarding selects plus multi-cycle load-use stall FSM.
// Optional macro HAZARD_MULDIV_STALL_EN adds MULDIV_BUSY and the MD_WAIT freeze state.
module hazard_resolve_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ID_VALID,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_RS_ADDR,
    input  logic [NUM_SRC-1:0]            ID_RS_USED,
    input  logic [REG_ADDR_W-1:0]         EX_RD,
    input  logic                          EX_REG_WRITE,
    input  logic                          EX_MEM_READ,
    input  logic [REG_ADDR_W-1:0]         MEM_RD,
    input  logic                          MEM_REG_WRITE,
    input  logic [REG_ADDR_W-1:0]         WB_RD,
    input  logic                          WB_REG_WRITE,
    input  logic                          FLUSH,
    output logic [2*NUM_SRC-1:0]          FORWARD_SEL,
    output logic                          STALL_PC,
    output logic                          STALL_IFID,
    output logic                          BUBBLE_IDEX,
`ifdef HAZARD_MULDIV_STALL_EN
    input  logic                          MULDIV_BUSY,
`endif
    output logic [1:0]                    DBG_STATE
);

    localparam int CNT_W = $clog2(LOAD_USE_STALL + 1);

    logic [2*NUM_SRC-1:0] fwd_vec;
    logic [NUM_SRC-1:0]   lu_hits;
    logic                 lu;

    hz_state_t            state, state_next, eff_state;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 stall, bubble;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .REG_ADDR_W(REG_ADDR_W)
        ) u_match (
            .rs           (ID_RS_ADDR[i*REG_ADDR_W +: REG_ADDR_W]),
            .used         (ID_RS_USED[i]),
            .ex_rd        (EX_RD),
            .ex_reg_write (EX_REG_WRITE),
            .ex_mem_read  (EX_MEM_READ),
            .mem_rd       (MEM_RD),
            .mem_reg_write(MEM_REG_WRITE),
            .wb_rd        (WB_RD),
            .wb_reg_write (WB_REG_WRITE),
            .fwd_sel      (fwd_vec[2*i +: 2]),
            .lu_hit       (lu_hits[i])
        );
    end

    assign lu = ID_VALID && (|lu_hits);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        bubble     = 1'b0;
        eff_state  = state;

`ifdef HAZARD_MULDIV_STALL_EN
        // Leaving MD_WAIT behaves exactly like the state that was frozen, so no stall cycle is lost.
        if (state == MD_WAIT && !MULDIV_BUSY) begin
            eff_state = (cnt != '0) ? LU_HOLD : IDLE;
        end
`endif

        case (eff_state)
            IDLE: begin
                state_next = IDLE;
                if (lu) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (LOAD_USE_STALL > 1) begin
                        state_next = LU_HOLD;
                        cnt_next   = CNT_W'(LOAD_USE_STALL - 1);
                    end
                end
            end
            LU_HOLD: begin
                // The first bubble already sits in EX, so a repeated lu here is not a new hazard.
                stall  = 1'b1;
                bubble = 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    state_next = LU_HOLD;
                    cnt_next   = cnt - CNT_W'(1);
                end
            end
            MD_WAIT: begin
                stall      = 1'b1;
                bubble     = 1'b0;
                state_next = MD_WAIT;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

`ifdef HAZARD_MULDIV_STALL_EN
        if (MULDIV_BUSY && !(FLUSH && state != MD_WAIT)) begin
            stall      = 1'b1;
            bubble     = 1'b0;
            state_next = MD_WAIT;
            cnt_next   = cnt;
        end
        if (FLUSH && state != MD_WAIT) begin
`else
        if (FLUSH) begin
`endif
            state_next = IDLE;
            cnt_next   = '0;
            stall      = 1'b0;
            bubble     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign STALL_PC    = stall && !RESET;
    assign STALL_IFID  = stall && !RESET;
    assign BUBBLE_IDEX = bubble && !RESET;
    assign FORWARD_SEL = RESET ? '0 : fwd_vec;
    assign DBG_STATE   = state;

endmodule

// File: tb/tb_hazard_resolve_unit.sv
// Directed bench: one instance with LOAD_USE_STALL=1 and one with LOAD_USE_STALL=3 on shared inputs.
module tb_hazard_resolve_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [9:0] id_rs_addr;
    logic [1:0] id_rs_used;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       flush;
`ifdef HAZARD_MULDIV_STALL_EN
    logic       muldiv_busy;
`endif

    logic [3:0] fwd_a, fwd_b;
    logic       stall_pc_a, stall_ifid_a, bubble_a;
    logic       stall_pc_b, stall_ifid_b, bubble_b;
    logic [1:0] state_a, state_b;

    int total = 0;
    int bad   = 0;

    hazard_resolve_unit #(
        .NUM_SRC(2), .REG_ADDR_W(5), .LOAD_USE_STALL(1)
    ) dut_a (
        .CLK(clk), .RESET(rst), .ID_VALID(id_valid),
        .ID_RS_ADDR(id_rs_addr), .ID_RS_USED(id_rs_used),
        .EX_RD(ex_rd), .EX_REG_WRITE(ex_reg_write), .EX_MEM_READ(ex_mem_read),
        .MEM_RD(mem_rd), .MEM_REG_WRITE(mem_reg_write),
        .WB_RD(wb_rd), .WB_REG_WRITE(wb_reg_write), .FLUSH(flush),
        .FORWARD_SEL(fwd_a), .STALL_PC(stall_pc_a), .STALL_IFID(stall_ifid_a),
        .BUBBLE_IDEX(bubble_a),
`ifdef HAZARD_MULDIV_STALL_EN
        .MULDIV_BUSY(muldiv_busy),
`endif
        .DBG_STATE(state_a)
    );

    hazard_resolve_unit #(
        .NUM_SRC(2), .REG_ADDR_W(5), .LOAD_USE_STALL(3)
    ) dut_b (
        .CLK(clk), .RESET(rst), .ID_VALID(id_valid),
        .ID_RS_ADDR(id_rs_addr), .ID_RS_USED(id_rs_used),
        .EX_RD(ex_rd), .EX_REG_WRITE(ex_reg_write), .EX_MEM_READ(ex_mem_read),
        .MEM_RD(mem_rd), .MEM_REG_WRITE(mem_reg_write),
        .WB_RD(wb_rd), .WB_REG_WRITE(wb_reg_write), .FLUSH(flush),
        .FORWARD_SEL(fwd_b), .STALL_PC(stall_pc_b), .STALL_IFID(stall_ifid_b),
        .BUBBLE_IDEX(bubble_b),
`ifdef HAZARD_MULDIV_STALL_EN
        .MULDIV_BUSY(muldiv_busy),
`endif
        .DBG_STATE(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_valid      = 1'b0;
        id_rs_addr    = '0;
        id_rs_used    = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        mem_rd        = '0;
        mem_reg_write = 1'b0;
        wb_rd         = '0;
        wb_reg_write  = 1'b0;
        flush         = 1'b0;
`ifdef HAZARD_MULDIV_STALL_EN
        muldiv_busy   = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // lw x<rd> in EX, ID instruction reading rd on source 'src'
    task automatic load_use(input logic [4:0] rd, input int src);
        clr();
        id_valid     = 1'b1;
        ex_rd        = rd;
        ex_mem_read  = 1'b1;
        ex_reg_write = 1'b1;
        if (src == 0) begin
            id_rs_addr = {5'd0, rd};
            id_rs_used = 2'b01;
        end else begin
            id_rs_addr = {rd, 5'd0};
            id_rs_used = 2'b10;
        end
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick();
        // hazards present while reset is high must not reach the outputs
        load_use(5'd3, 0);
        mem_rd = 5'd3; mem_reg_write = 1'b1;
        sample();
        chk("rst_stall_a", stall_pc_a, 0);
        chk("rst_bubble_b", bubble_b, 0);
        chk("rst_fwd_a", fwd_a, 0);
        tick();
        chk("rst_state_b", state_b, 0);
        rst = 1'b0;
        clr();

        // ALU chain through MEM
        id_valid = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1;
        id_rs_addr = {5'd0, 5'd5}; id_rs_used = 2'b01;
        sample();
        chk("alu_fwd", fwd_a, 4'b0001);
        chk("alu_nostall", stall_pc_a, 0);
        tick();

        // double producer on rs2: MEM wins
        clr();
        id_valid = 1'b1; mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1;
        id_rs_addr = {5'd7, 5'd1}; id_rs_used = 2'b11;
        sample();
        chk("dbl_fwd", fwd_b, 4'b0100);
        tick();

        // WB only on rs1; rs2 matches but is unused
        clr();
        id_valid = 1'b1; wb_rd = 5'd9; wb_reg_write = 1'b1;
        id_rs_addr = {5'd9, 5'd9}; id_rs_used = 2'b01;
        sample();
        chk("wb_fwd", fwd_a, 4'b0010);
        tick();

        // x0 never stalls or forwards
        load_use(5'd0, 0);
        mem_rd = 5'd0; mem_reg_write = 1'b1;
        sample();
        chk("x0_stall_a", stall_pc_a, 0);
        chk("x0_stall_b", stall_pc_b, 0);
        chk("x0_fwd", fwd_a, 0);
        tick();

        // ALU producer in EX: no stall
        load_use(5'd4, 0);
        ex_mem_read = 1'b0;
        sample();
        chk("exalu_stall", stall_pc_a, 0);
        tick();

        // load-use, pipeline advancing normally
        load_use(5'd3, 0);
        sample();
        chk("lu1_stall_a", stall_pc_a, 1);
        chk("lu1_ifid_a", stall_ifid_a, 1);
        chk("lu1_bubble_a", bubble_a, 1);
        chk("lu1_stall_b", stall_pc_b, 1);
        tick();
        clr();
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd3}; id_rs_used = 2'b01;
        mem_rd = 5'd3; mem_reg_write = 1'b1;
        sample();
        chk("lu2_stall_a", stall_pc_a, 0);
        chk("lu2_fwd_a", fwd_a, 4'b0001);
        chk("lu2_stall_b", stall_pc_b, 1);
        chk("lu2_state_b", state_b, 1);
        tick();
        mem_reg_write = 1'b0; wb_rd = 5'd3; wb_reg_write = 1'b1;
        sample();
        chk("lu3_fwd_a", fwd_a, 4'b0010);
        chk("lu3_stall_b", stall_pc_b, 1);
        chk("lu3_bubble_b", bubble_b, 1);
        tick();
        sample();
        chk("lu4_stall_b", stall_pc_b, 0);
        chk("lu4_state_b", state_b, 0);
        tick();

        // FLUSH in the second stall cycle
        load_use(5'd3, 0);
        sample();
        chk("fl1_stall_b", stall_pc_b, 1);
        tick();
        clr();
        flush = 1'b1;
        sample();
        chk("fl2_stall_b", stall_pc_b, 0);
        chk("fl2_bubble_b", bubble_b, 0);
        tick();
        clr();
        sample();
        chk("fl3_stall_b", stall_pc_b, 0);
        chk("fl3_state_b", state_b, 0);
        tick();

        // RESET in the second stall cycle
        load_use(5'd3, 0);
        sample();
        chk("rs1_stall_b", stall_pc_b, 1);
        tick();
        clr();
        rst = 1'b1;
        id_valid = 1'b1; id_rs_addr = {5'd0, 5'd3}; id_rs_used = 2'b01;
        mem_rd = 5'd3; mem_reg_write = 1'b1;
        sample();
        chk("rs2_stall_b", stall_pc_b, 0);
        chk("rs2_fwd_b", fwd_b, 0);
        tick();
        rst = 1'b0;
        sample();
        chk("rs3_stall_b", stall_pc_b, 0);
        chk("rs3_state_b", state_b, 0);
        chk("rs3_fwd_b", fwd_b, 4'b0001);
        tick();

        // FLUSH and load-use together
        load_use(5'd6, 0);
        flush = 1'b1;
        sample();
        chk("fllu_stall_a", stall_pc_a, 0);
        chk("fllu_stall_b", stall_pc_b, 0);
        tick();
        clr();
        sample();
        chk("fllu_state_b", state_b, 0);
        tick();

        // ID bubble does not stall
        load_use(5'd6, 0);
        id_valid = 1'b0;
        sample();
        chk("idinv_stall", stall_pc_a, 0);
        tick();

        // load-use on the second source
        load_use(5'd8, 1);
        sample();
        chk("rs2lu_stall_a", stall_pc_a, 1);
        chk("rs2lu_bubble_a", bubble_a, 1);
        tick();
        clr();
        tick();
        tick();
        sample();
        chk("rs2lu_drain_b", state_b, 0);
        tick();

`ifdef HAZARD_MULDIV_STALL_EN
        clr();
        muldiv_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("md_stall", stall_pc_a, 1);
            chk("md_bubble", bubble_a, 0);
            tick();
        end
        muldiv_busy = 1'b0;
        sample();
        chk("md_release", stall_pc_a, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
